pe_serial_mac: RTL and testbench
================================

Name: pe_serial_mac

Overview:
- Bit-serial multiply-accumulate stage inside the processing element (PE).
- Accepts unsigned operand pairs over a valid/ready handshake and multiplies each pair by shift-and-add, one multiplier bit per cycle.
- Accumulates the products and presents the final sum when a pair tagged "last" completes.
- Its out_acc/out_valid feed directly into the PE's output flip-flop register stage, which captures the result.

Parameters:
- WIDTH, 8, operand width in bits (unsigned).
- ACC_WIDTH, 20, accumulator width in bits; must be >= 2*WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  stage can accept a pair.
- in_a  input  WIDTH  multiplicand.
- in_b  input  WIDTH  multiplier.
- in_last  input  1  pair closes the current accumulation.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream register accepts the result.
- out_acc  output  ACC_WIDTH  accumulated sum.
- out_ovf  output  1  sticky flag: the accumulator wrapped during this accumulation.
- busy  output  1  high in MULT or DONE.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_acc=0, out_ovf=0, busy=0, internal product/counter=0.
- Reset priority: rst wins over every other input in the same cycle.
- States: IDLE, MULT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a, b, last; clear partial product; bit counter=0; go to MULT.
- MULT:
  - in_ready=0.
  - Each cycle: if b[counter] is set, add (a << counter) to the 2*WIDTH-bit partial product; counter increments.
  - Always exactly WIDTH cycles; no early termination, even for zero operands.
  - On the final cycle, the completed product is added to acc.
  - Next state is DONE if the latched last=1, otherwise IDLE.
  - Timing: accept at edge E0, accumulate at edge E0+WIDTH. out_valid is first visible after edge E0+WIDTH.
- Accumulation arithmetic:
  - acc = (acc + product) mod 2^ACC_WIDTH.
  - A carry out of bit ACC_WIDTH-1 sets out_ovf.
  - out_ovf stays set until the result is consumed.
- DONE:
  - out_valid=1; out_acc and out_ovf are held stable while out_ready=0.
  - On out_valid&&out_ready: acc=0, out_ovf=0, out_valid=0, go to IDLE.
  - out_ready high in the first DONE cycle completes the handshake at that edge.
- Throughput: at most one pair per WIDTH+1 cycles. in_valid while in_ready=0 is ignored; the upstream stage holds the pair.
- out_acc:
  - Reflects the running acc in every state.
  - Only meaningful when out_valid=1.
- busy: 1 in MULT or DONE.
- Reset mid-operation (MULT or DONE): the in-flight pair and the accumulated sum are discarded with no output. Next cycle is IDLE with reset values.
- in_last on the very first pair: result equals that single product.

Decomposition:
- Shared package pe_pkg holds:
  - the state enum (IDLE/MULT/DONE);
  - PE_WIDTH/PE_ACC_WIDTH defaults;
  - the counter width constant $clog2(WIDTH).
- One natural sub-module: pe_shift_add_mult.
  - Inputs: start, a, b. Outputs: done, product.
  - Contains the counter and partial product.
  - The parent holds the FSM, accumulator and handshakes.

Test Plan:
- Reset: hold rst 2 cycles with random inputs -> in_ready=1, out_valid=0, out_acc=0, out_ovf=0, busy=0.
- Single pair:
  - Stimulus: a=3, b=5, last=1 accepted at E0.
  - Response: out_valid first high after E0+8; out_acc=15; out_ovf=0; in_ready=0 during cycles E0+1..E0+8.
- Chain:
  - Stimulus: (255,255), (255,255), (1,1,last).
  - Response: out_acc=130051; out_ovf=0; then after the handshake, acc=0 and in_ready=1.
- Overflow:
  - Stimulus: 17 pairs of (255,255), last on the 17th.
  - Response: out_acc=56849 (1105425 mod 2^20); out_ovf=1; flag clears after consumption.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles in DONE, with in_valid=1 throughout.
  - Response: out_valid, out_acc and out_ovf stable; no pair accepted; handshake completes on the cycle out_ready=1.
- Reset mid-MULT:
  - Stimulus: rst asserted in the 3rd MULT cycle of pair (9,9); then pair (2,7,last).
  - Response: next cycle is IDLE with out_valid=0; final out_acc=14, with no contribution from 81.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types and defaults for the PE bit-serial multiply-accumulate stage.
package pe_pkg;

    localparam int PE_WIDTH     = 8;
    localparam int PE_ACC_WIDTH = 20;
    localparam int PE_CNT_WIDTH = $clog2(PE_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        DONE
    } state_t;

    // Bit-counter width for a given operand width; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/pe_shift_add_mult.sv
// Shift-and-add unsigned multiplier: one multiplier bit per cycle, always WIDTH cycles.
module pe_shift_add_mult
    import pe_pkg::*;
#(
    parameter int WIDTH = PE_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] partial;
    logic [2*WIDTH-1:0] addend;
    logic               running;

    // product includes the current bit, so it is complete in the same cycle done is high.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        addend = '0;
        if (b_q[cnt])
            addend = {{WIDTH{1'b0}}, a_q} << cnt;
        product = partial + addend;
        done    = running && (cnt == LAST_CNT);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            cnt     <= '0;
            partial <= '0;
            running <= 1'b0;
        end else if (start) begin
            a_q     <= a;
            b_q     <= b;
            cnt     <= '0;
            partial <= '0;
            running <= 1'b1;
        end else if (running) begin
            partial <= product;
            if (done) begin
                cnt     <= '0;
                running <= 1'b0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/pe_serial_mac.sv
// PE multiply-accumulate stage: FSM, accumulator with sticky overflow, and both handshakes.
module pe_serial_mac
    import pe_pkg::*;
#(
    parameter int WIDTH     = PE_WIDTH,
    parameter int ACC_WIDTH = PE_ACC_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_acc,
    output logic                 out_ovf,
    output logic                 busy
);

    state_t               state;
    logic [ACC_WIDTH-1:0] acc;
    logic                 ovf;
    logic                 last_q;
    logic                 start;
    logic                 mult_done;
    logic [2*WIDTH-1:0]   product;
    logic [ACC_WIDTH:0]   sum;

    assign start = in_valid && in_ready;

    pe_shift_add_mult #(
        .WIDTH (WIDTH)
    ) u_mult (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (in_a),
        .b       (in_b),
        .done    (mult_done),
        .product (product)
    );

    // One extra bit catches the carry out of the accumulator.
    assign sum = {1'b0, acc} + {{(ACC_WIDTH + 1 - 2*WIDTH){1'b0}}, product};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            acc       <= '0;
            ovf       <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        last_q   <= in_last;
                        state    <= MULT;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                MULT: begin
                    if (mult_done) begin
                        acc <= sum[ACC_WIDTH-1:0];
                        ovf <= ovf | sum[ACC_WIDTH];
                        if (last_q) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state    <= IDLE;
                            in_ready <= 1'b1;
                            busy     <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        acc       <= '0;
                        ovf       <= 1'b0;
                        out_valid <= 1'b0;
                        state     <= IDLE;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign out_acc = acc;
    assign out_ovf = ovf;

endmodule

// File: tb/tb_pe_serial_mac.sv
// Directed-vector bench for pe_serial_mac with hand-computed expected sums.
module tb_pe_serial_mac;

    localparam int W  = 8;
    localparam int AW = 20;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_acc;
    logic          out_ovf;
    logic          busy;

    int n_total = 0;
    int n_pass  = 0;

    pe_serial_mac #(
        .WIDTH     (W),
        .ACC_WIDTH (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it before sampling or driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for in_ready, then presents one pair for exactly one edge.
    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic last);
        int waited;
        waited = 0;
        while (in_ready !== 1'b1 && waited < 40) begin
            step();
            waited++;
        end
        n_total++;
        if (in_ready !== 1'b1)
            $display("FAIL accept_timeout: in_ready=%b required 1 within 40 cycles", in_ready);
        else
            n_pass++;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done();
        int waited;
        waited = 0;
        while (out_valid !== 1'b1 && waited < 40) begin
            step();
            waited++;
        end
        n_total++;
        if (out_valid !== 1'b1)
            $display("FAIL done_timeout: out_valid=%b required 1 within 40 cycles", out_valid);
        else
            n_pass++;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid  = 1'($urandom);
            in_a      = W'($urandom);
            in_b      = W'($urandom);
            in_last   = 1'($urandom);
            out_ready = 1'($urandom);
            step();
        end
        n_total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_acc !== '0 || out_ovf !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_values: in_ready=%b out_valid=%b out_acc=%0d out_ovf=%b busy=%b required 1 0 0 0 0",
                     in_ready, out_valid, out_acc, out_ovf, busy);
        else
            n_pass++;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b0;
        step();
    endtask

    task automatic test_single();
        logic bad;
        accept(8'd3, 8'd5, 1'b1);
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b1) bad = 1'b1;
        end
        n_total++;
        if (bad)
            $display("FAIL single_mult_window: in_ready/out_valid/busy wrong during edges E0..E0+7 (required 0/0/1)");
        else
            n_pass++;
        step();
        n_total++;
        if (out_valid !== 1'b1 || out_acc !== 20'd15 || out_ovf !== 1'b0 || busy !== 1'b1)
            $display("FAIL single_result: out_valid=%b out_acc=%0d out_ovf=%b busy=%b required 1 15 0 1",
                     out_valid, out_acc, out_ovf, busy);
        else
            n_pass++;
        consume();
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_acc !== '0 || busy !== 1'b0)
            $display("FAIL single_consume: out_valid=%b in_ready=%b out_acc=%0d busy=%b required 0 1 0 0",
                     out_valid, in_ready, out_acc, busy);
        else
            n_pass++;
    endtask

    task automatic test_chain();
        accept(8'd255, 8'd255, 1'b0);
        accept(8'd255, 8'd255, 1'b0);
        accept(8'd1, 8'd1, 1'b1);
        wait_done();
        n_total++;
        if (out_acc !== 20'd130051 || out_ovf !== 1'b0)
            $display("FAIL chain_result: out_acc=%0d out_ovf=%b required 130051 0", out_acc, out_ovf);
        else
            n_pass++;
        consume();
        n_total++;
        if (out_acc !== '0 || in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL chain_consume: out_acc=%0d in_ready=%b out_valid=%b required 0 1 0",
                     out_acc, in_ready, out_valid);
        else
            n_pass++;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 17; i++)
            accept(8'd255, 8'd255, (i == 16) ? 1'b1 : 1'b0);
        wait_done();
        n_total++;
        if (out_acc !== 20'd56849 || out_ovf !== 1'b1)
            $display("FAIL overflow_result: out_acc=%0d out_ovf=%b required 56849 1", out_acc, out_ovf);
        else
            n_pass++;
        consume();
        n_total++;
        if (out_ovf !== 1'b0 || out_acc !== '0)
            $display("FAIL overflow_clear: out_ovf=%b out_acc=%0d required 0 0", out_ovf, out_acc);
        else
            n_pass++;
    endtask

    task automatic test_backpressure();
        logic bad;
        accept(8'd4, 8'd6, 1'b1);
        wait_done();
        in_valid = 1'b1;
        in_a     = 8'd1;
        in_b     = 8'd1;
        in_last  = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (out_valid !== 1'b1 || out_acc !== 20'd24 || out_ovf !== 1'b0 || in_ready !== 1'b0)
                bad = 1'b1;
        end
        n_total++;
        if (bad)
            $display("FAIL backpressure_hold: out_valid=%b out_acc=%0d out_ovf=%b in_ready=%b required 1 24 0 0",
                     out_valid, out_acc, out_ovf, in_ready);
        else
            n_pass++;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_acc !== '0)
            $display("FAIL backpressure_release: out_valid=%b in_ready=%b busy=%b out_acc=%0d required 0 1 0 0",
                     out_valid, in_ready, busy, out_acc);
        else
            n_pass++;
    endtask

    task automatic test_reset_mid();
        logic seen;
        accept(8'd9, 8'd9, 1'b1);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_acc !== '0)
            $display("FAIL reset_mid_state: in_ready=%b out_valid=%b busy=%b out_acc=%0d required 1 0 0 0",
                     in_ready, out_valid, busy, out_acc);
        else
            n_pass++;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        n_total++;
        if (seen)
            $display("FAIL reset_mid_no_output: out_valid rose after reset, required 0");
        else
            n_pass++;
        accept(8'd2, 8'd7, 1'b1);
        wait_done();
        n_total++;
        if (out_acc !== 20'd14 || out_ovf !== 1'b0)
            $display("FAIL reset_mid_result: out_acc=%0d out_ovf=%b required 14 0", out_acc, out_ovf);
        else
            n_pass++;
        consume();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #1;
        test_reset();
        test_single();
        test_chain();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
